n_sync_tx_scheduler: RTL and testbench

- Sits between the gradient workers and the shared N buffer (32-bit FIFO: push via input_signal/N_buffer_ready, pop via remove_signal, head on m_axis_tx_TDATA).
- Round-robin arbitrates NUM_REQ worker requests into the buffer, one push per cycle.
- Drains each buffered N (byte count) into TCP tx metadata commands, segmenting at MAX_SEG bytes and retrying segments that return an error status.
- The buffer exposes no valid flag, so this block owns the authoritative occupancy count.

---
 rtl/n_sync_tx_scheduler_if.sv | 36 +++
 rtl/n_sync_tx_scheduler.sv | 169 ++++++++++++++++
 tb/tb_n_sync_tx_scheduler.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/n_sync_tx_scheduler_if.sv
// Worker/buffer/TCP-tx bundle around n_sync_tx_scheduler.
//   master: scheduler side (drives grants, buffer push/pop, tx commands)
//   slave : environment side (workers, N buffer, TCP tx engine)
interface n_sync_tx_scheduler_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_N;
  logic [NUM_REQ-1:0]    req_ready;
  logic [31:0]           buf_N;
  logic                  buf_input_signal;
  logic                  buf_ready;
  logic                  buf_remove_signal;
  logic [31:0]           buf_head;
  logic [15:0]           session_id;
  logic                  tx_meta_valid;
  logic                  tx_meta_ready;
  logic [15:0]           tx_meta_session;
  logic [15:0]           tx_meta_length;
  logic                  tx_status_valid;
  logic [1:0]            tx_status_error;

  modport master (
    input  req_valid, req_N, buf_ready, buf_head, session_id,
           tx_meta_ready, tx_status_valid, tx_status_error,
    output req_ready, buf_N, buf_input_signal, buf_remove_signal,
           tx_meta_valid, tx_meta_session, tx_meta_length
  );

  modport slave (
    output req_valid, req_N, buf_ready, buf_head, session_id,
           tx_meta_ready, tx_status_valid, tx_status_error,
    input  req_ready, buf_N, buf_input_signal, buf_remove_signal,
           tx_meta_valid, tx_meta_session, tx_meta_length
  );
endinterface

// File: rtl/n_sync_tx_scheduler.sv
// Round-robin enqueue of worker N values into the shared N buffer, and
// drain of buffered byte counts into segmented, retried TCP tx commands.
// Ports:
//   clk, rst   clock and asynchronous active-low reset
//   bus        worker requests, buffer push/pop/head, tx metadata + status
//   occupancy  number of entries currently held in the N buffer
//   busy       drain engine is working on a head entry
module n_sync_tx_scheduler #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_BITS  = 5,
  parameter int unsigned MAX_SEG    = 1408,
  parameter int unsigned RETRY_WAIT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  n_sync_tx_scheduler_if.master   bus,
  output logic [ADDR_BITS:0]      occupancy,
  output logic                    busy
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(RETRY_WAIT + 1);
  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH_W = (ADDR_BITS+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_META, S_WAIT, S_BACKOFF
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   win;
  logic [PTR_W-1:0]   cand;
  logic               found;
  logic [31:0]        win_n;
  logic [NUM_REQ-1:0] grant;
  logic               can_push;
  logic               push;
  logic               pop;
  logic               ok_last;
  logic               zero_drop;
  logic [31:0]        remaining;
  logic [31:0]        seg_ext;
  logic [CNT_W-1:0]   retry;

  // First requester at or after the round-robin pointer, with wrap
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((32'(ptr) + k) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Winner's N slice
  always_comb begin
    win_n = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win == PTR_W'(i)) win_n = bus.req_N[32*i +: 32];
    end
  end

  assign can_push = bus.buf_ready && (occupancy < DEPTH_W);

  always_comb begin
    grant = '0;
    if (can_push && found) grant[win] = 1'b1;
  end

  assign push                 = |grant;
  assign bus.req_ready        = grant;
  assign bus.buf_input_signal = push;
  assign bus.buf_N            = win_n;

  // Pop in the same cycle the buffer is released so IDLE never re-reads a stale head
  assign seg_ext   = {16'd0, bus.tx_meta_length};
  assign ok_last   = (state == S_WAIT) && bus.tx_status_valid &&
                     (bus.tx_status_error == 2'd0) && (remaining == seg_ext);
  assign zero_drop = (state == S_IDLE) && (occupancy != '0) && (bus.buf_head == 32'd0);
  assign pop       = ok_last || zero_drop;
  assign bus.buf_remove_signal = pop;

  // Round-robin pointer and occupancy count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr       <= '0;
      occupancy <= '0;
    end else begin
      if (push) ptr <= (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + (ADDR_BITS+1)'(1);
        2'b01:   occupancy <= occupancy - (ADDR_BITS+1)'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Drain engine: segment the head N into tx commands, back off on errors
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= S_IDLE;
      busy                <= 1'b0;
      remaining           <= '0;
      retry               <= '0;
      bus.tx_meta_valid   <= 1'b0;
      bus.tx_meta_session <= '0;
      bus.tx_meta_length  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (occupancy != '0) begin
            remaining <= bus.buf_head;
            if (bus.buf_head != 32'd0) begin
              state <= S_LOAD;
              busy  <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          bus.tx_meta_length  <= (remaining > 32'(MAX_SEG)) ? 16'(MAX_SEG) : remaining[15:0];
          bus.tx_meta_session <= bus.session_id;
          bus.tx_meta_valid   <= 1'b1;
          state               <= S_META;
        end
        S_META: begin
          if (bus.tx_meta_ready) begin
            bus.tx_meta_valid <= 1'b0;
            state             <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.tx_status_valid) begin
            if (bus.tx_status_error == 2'd0) begin
              remaining <= remaining - seg_ext;
              if (remaining == seg_ext) begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end else begin
                state <= S_LOAD;
              end
            end else begin
              retry <= CNT_W'(RETRY_WAIT);
              state <= S_BACKOFF;
            end
          end
        end
        S_BACKOFF: begin
          if (retry <= CNT_W'(1)) begin
            retry             <= '0;
            bus.tx_meta_valid <= 1'b1;
            state             <= S_META;
          end else begin
            retry <= retry - CNT_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_n_sync_tx_scheduler.sv
// Directed bench for n_sync_tx_scheduler with a behavioural N buffer.
module tb_n_sync_tx_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] occupancy;
  logic       busy;
  int         checks = 0;
  int         failures = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  n_sync_tx_scheduler_if #(.NUM_REQ(4)) bus_if ();

  n_sync_tx_scheduler #(
    .NUM_REQ(4), .ADDR_BITS(5), .MAX_SEG(1408), .RETRY_WAIT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if),
    .occupancy(occupancy),
    .busy(busy)
  );

  // First-word fall-through buffer sharing the scheduler reset
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      bus_if.buf_head <= 32'd0;
    end else begin
      if (bus_if.buf_remove_signal && q.size() > 0) void'(q.pop_front());
      if (bus_if.buf_input_signal) q.push_back(bus_if.buf_N);
      bus_if.buf_head <= (q.size() > 0) ? q[0] : 32'd0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus_if.req_valid       = '0;
    bus_if.req_N           = '0;
    bus_if.buf_ready       = 1'b1;
    bus_if.session_id      = 16'h5A5A;
    bus_if.tx_meta_ready   = 1'b0;
    bus_if.tx_status_valid = 1'b0;
    bus_if.tx_status_error = 2'd0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_n(input int i, input logic [31:0] n);
    bus_if.req_N[32*i +: 32] = n;
  endtask

  // Wait for a command, accept it, return a status; mask is req_valid during the status cycle
  task automatic serve(input string name, input logic [15:0] exp_len, input logic [1:0] err,
                       input logic exp_pop, input logic [3:0] mask);
    int n = 0;
    while (!bus_if.tx_meta_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_meta_valid"}, 64'(bus_if.tx_meta_valid), 64'd1);
    check({name, "_length"}, 64'(bus_if.tx_meta_length), 64'(exp_len));
    check({name, "_session"}, 64'(bus_if.tx_meta_session), 64'h5A5A);
    bus_if.tx_meta_ready = 1'b1;
    @(negedge clk);
    bus_if.tx_meta_ready   = 1'b0;
    bus_if.tx_status_valid = 1'b1;
    bus_if.tx_status_error = err;
    bus_if.req_valid       = mask;
    #1;
    check({name, "_pop"}, 64'(bus_if.buf_remove_signal), 64'(exp_pop));
    check({name, "_push"}, 64'(bus_if.buf_input_signal), 64'(mask != 4'd0));
    @(negedge clk);
    bus_if.tx_status_valid = 1'b0;
    bus_if.tx_status_error = 2'd0;
    bus_if.req_valid       = '0;
  endtask

  typedef struct {
    logic [3:0] valid;
    logic       rdy;
    logic [3:0] exp_ready;
    int         exp_idx;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 0};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 2};
    vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 3};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 0};
    vecs[5]  = '{4'b1001, 1'b1, 4'b1000, 3};
    vecs[6]  = '{4'b0110, 1'b1, 4'b0010, 1};
    vecs[7]  = '{4'b0010, 1'b1, 4'b0010, 1};
    vecs[8]  = '{4'b0000, 1'b1, 4'b0000, 0};
    vecs[9]  = '{4'b0001, 1'b1, 4'b0001, 0};
    vecs[10] = '{4'b1100, 1'b1, 4'b0100, 2};
    vecs[11] = '{4'b1111, 1'b0, 4'b0000, 0};
    vecs[12] = '{4'b1111, 1'b1, 4'b1000, 3};

    // Reset state
    idle_inputs();
    repeat (2) @(negedge clk);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_meta_valid", 64'(bus_if.tx_meta_valid), 64'd0);
    check("rst_meta_length", 64'(bus_if.tx_meta_length), 64'd0);
    check("rst_remove", 64'(bus_if.buf_remove_signal), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Round-robin grant table; drain is stalled by tx_meta_ready=0
    for (int i = 0; i < 4; i++) set_n(i, 32'h1000_0000 + 32'(i));
    for (int v = 0; v < 13; v++) begin
      bus_if.req_valid = vecs[v].valid;
      bus_if.buf_ready = vecs[v].rdy;
      #1;
      check($sformatf("rr%0d_ready", v), 64'(bus_if.req_ready), 64'(vecs[v].exp_ready));
      check($sformatf("rr%0d_push", v), 64'(bus_if.buf_input_signal), 64'(vecs[v].exp_ready != 4'd0));
      if (vecs[v].exp_ready != 4'd0)
        check($sformatf("rr%0d_bufN", v), 64'(bus_if.buf_N), 64'(32'h1000_0000 + 32'(vecs[v].exp_idx)));
      @(negedge clk);
    end
    bus_if.req_valid = '0;
    check("rr_occupancy", 64'(occupancy), 64'd11);

    // Single N=3000 from worker 1: 1408, 1408, 184
    do_reset();
    bus_if.req_valid = 4'b0010;
    set_n(1, 32'd3000);
    #1;
    check("seg_grant", 64'(bus_if.req_ready), 64'b0010);
    @(negedge clk);
    bus_if.req_valid = '0;
    check("seg_occ1", 64'(occupancy), 64'd1);
    check("seg_lat0", 64'(bus_if.tx_meta_valid), 64'd0);
    @(negedge clk);
    check("seg_lat1", 64'(bus_if.tx_meta_valid), 64'd0);
    check("seg_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("seg_lat2", 64'(bus_if.tx_meta_valid), 64'd1);
    serve("seg_a", 16'd1408, 2'd0, 1'b0, 4'b0000);
    serve("seg_b", 16'd1408, 2'd0, 1'b0, 4'b0000);
    check("seg_occ_before_last", 64'(occupancy), 64'd1);
    serve("seg_c", 16'd184, 2'd0, 1'b1, 4'b0000);
    check("seg_occ0", 64'(occupancy), 64'd0);
    check("seg_idle", 64'(busy), 64'd0);

    // Fill to depth with the drain stalled, then pop/refill and push+pop together
    do_reset();
    for (int i = 0; i < 4; i++) set_n(i, 32'd10 + 32'(i));
    bus_if.req_valid = 4'b1111;
    repeat (40) @(negedge clk);
    #1;
    check("full_occ", 64'(occupancy), 64'd32);
    check("full_ready", 64'(bus_if.req_ready), 64'd0);
    check("full_push", 64'(bus_if.buf_input_signal), 64'd0);
    bus_if.req_valid = '0;
    serve("full_a", 16'd10, 2'd0, 1'b1, 4'b0000);
    check("full_occ31", 64'(occupancy), 64'd31);
    serve("full_b", 16'd11, 2'd0, 1'b1, 4'b0001);
    check("full_pushpop_occ", 64'(occupancy), 64'd31);
    bus_if.req_valid = 4'b0100;
    #1;
    check("full_refill_grant", 64'(bus_if.req_ready), 64'b0100);
    @(negedge clk);
    #1;
    check("full_refill_occ", 64'(occupancy), 64'd32);
    check("full_refill_block", 64'(bus_if.req_ready), 64'd0);
    bus_if.req_valid = '0;

    // Zero entry dropped in IDLE, then N=100
    do_reset();
    bus_if.req_valid = 4'b0001;
    set_n(0, 32'd0);
    #1;
    check("zero_grant0", 64'(bus_if.req_ready), 64'b0001);
    @(negedge clk);
    bus_if.req_valid = 4'b0100;
    set_n(2, 32'd100);
    #1;
    check("zero_pop", 64'(bus_if.buf_remove_signal), 64'd1);
    check("zero_grant2", 64'(bus_if.req_ready), 64'b0100);
    @(negedge clk);
    bus_if.req_valid = '0;
    check("zero_occ", 64'(occupancy), 64'd1);
    check("zero_no_meta", 64'(bus_if.tx_meta_valid), 64'd0);
    serve("zero_b", 16'd100, 2'd0, 1'b1, 4'b0000);
    check("zero_occ0", 64'(occupancy), 64'd0);

    // Error status: 16 idle cycles, then re-issue of the same segment
    do_reset();
    bus_if.req_valid = 4'b1000;
    set_n(3, 32'd500);
    @(negedge clk);
    bus_if.req_valid = '0;
    serve("err_a", 16'd500, 2'd1, 1'b0, 4'b0000);
    cnt = 0;
    while (!bus_if.tx_meta_valid && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check("err_backoff_cycles", 64'(cnt), 64'd16);
    check("err_occ_held", 64'(occupancy), 64'd1);
    serve("err_b", 16'd500, 2'd0, 1'b1, 4'b0000);
    check("err_occ0", 64'(occupancy), 64'd0);

    // Asynchronous reset while waiting for status with 5 entries buffered
    do_reset();
    bus_if.req_valid = 4'b0001;
    set_n(0, 32'd200);
    repeat (5) @(negedge clk);
    bus_if.req_valid = '0;
    cnt = 0;
    while (!bus_if.tx_meta_valid && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    bus_if.tx_meta_ready = 1'b1;
    @(negedge clk);
    bus_if.tx_meta_ready = 1'b0;
    check("arst_occ5", 64'(occupancy), 64'd5);
    check("arst_busy1", 64'(busy), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_occ", 64'(occupancy), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_meta_valid", 64'(bus_if.tx_meta_valid), 64'd0);
    check("arst_meta_length", 64'(bus_if.tx_meta_length), 64'd0);
    check("arst_remove", 64'(bus_if.buf_remove_signal), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    bus_if.tx_status_valid = 1'b1;
    #1;
    check("arst_stray_pop", 64'(bus_if.buf_remove_signal), 64'd0);
    @(negedge clk);
    bus_if.tx_status_valid = 1'b0;
    check("arst_stray_occ", 64'(occupancy), 64'd0);
    check("arst_stray_busy", 64'(busy), 64'd0);
    check("arst_stray_meta", 64'(bus_if.tx_meta_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
